// File: rtl/mips_memory_arbiter.sv
// mips_memory_arbiter
// Shares one single-ported, word-wide memory between instruction fetch and
// the load/store stage. One held-level request is granted at a time. The
// granted request is latched, the memory is driven for LATENCY cycles, and
// a one-cycle done pulse returns aligned, zero-extended read data.
//
// Ports
//   clock, reset                 rising-edge clock, async active-high reset
//   fetchReq/fetchAddr           fetch request level and word address
//   fetchDone/fetchData          fetch completion pulse and instruction word
//   dataReq/dataWriteEnable      data request level, 1 = store
//   dataByteEnable               00 none, 01 byte, 10 half, 11 word
//   dataAddr/dataWriteData       data byte address, right-justified store data
//   dataDone/dataReadData        data completion pulse and load data
//   dataMisaligned               qualifies dataDone: access was skipped
//   memEnable/memWrite           memory strobes
//   memLaneMask/memAddr          byte lanes and word address
//   memWriteData/memReadData     lane-replicated store data, read word
module mips_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetchReq,
  input  logic [ADDR_WIDTH-1:0] fetchAddr,
  output logic                  fetchDone,
  output logic [31:0]           fetchData,
  input  logic                  dataReq,
  input  logic                  dataWriteEnable,
  input  logic [1:0]            dataByteEnable,
  input  logic [ADDR_WIDTH-1:0] dataAddr,
  input  logic [31:0]           dataWriteData,
  output logic                  dataDone,
  output logic [31:0]           dataReadData,
  output logic                  dataMisaligned,
  output logic                  memEnable,
  output logic                  memWrite,
  output logic [3:0]            memLaneMask,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWriteData,
  input  logic [31:0]           memReadData
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  typedef struct packed {
    logic                  is_data;
    logic                  wr;
    logic [1:0]            be;
    logic                  mis;
    logic                  skip;   // no memory access (none or misaligned)
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            mask;
    logic [31:0]           wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          req_q, req_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   rdata_q, rdata_ext;
  logic          last_grant;       // 0 = fetch, 1 = data
  logic          grant_data, grant_fetch;

  // Arbitration: a tie goes to whoever was not served last.
  assign grant_data  = dataReq && (!fetchReq || !last_grant);
  assign grant_fetch = fetchReq && !grant_data;

  // Build the request record that is latched on grant.
  always_comb begin
    req_nxt = '0;
    if (grant_data) begin
      req_nxt.is_data = 1'b1;
      req_nxt.be      = dataByteEnable;
      req_nxt.addr    = dataAddr;
      req_nxt.mis     = (dataByteEnable == 2'b10 && dataAddr[0]) ||
                        (dataByteEnable == 2'b11 && dataAddr[1:0] != 2'b00);
      req_nxt.skip    = (dataByteEnable == 2'b00) || req_nxt.mis;
      req_nxt.wr      = dataWriteEnable && !req_nxt.skip;
      case (dataByteEnable)
        2'b01: begin
          req_nxt.mask  = 4'b0001 << dataAddr[1:0];
          req_nxt.wdata = {4{dataWriteData[7:0]}};
        end
        2'b10: begin
          req_nxt.mask  = dataAddr[1] ? 4'b1100 : 4'b0011;
          req_nxt.wdata = {2{dataWriteData[15:0]}};
        end
        default: begin
          req_nxt.mask  = 4'b1111;
          req_nxt.wdata = dataWriteData;
        end
      endcase
    end else begin
      req_nxt.be   = 2'b11;
      req_nxt.addr = fetchAddr;
      req_nxt.mask = 4'b1111;
    end
  end

  // Right-justify and zero-extend the addressed lanes of the read word.
  always_comb begin
    rdata_ext = memReadData;
    case (req_q.be)
      2'b01:   rdata_ext = {24'b0, memReadData[{req_q.addr[1:0], 3'b000} +: 8]};
      2'b10:   rdata_ext = {16'b0, req_q.addr[1] ? memReadData[31:16] : memReadData[15:0]};
      default: rdata_ext = memReadData;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_data || grant_fetch)
                 state_nxt = req_nxt.skip ? RESPOND : ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = RESPOND;
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, latency counter, read capture, grant history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q      <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      last_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: if (grant_data || grant_fetch) begin
          req_q   <= req_nxt;
          cnt     <= CW'(LATENCY - 1);
          rdata_q <= '0;
        end
        ACCESS: begin
          if (cnt == '0) rdata_q <= req_q.wr ? 32'b0 : rdata_ext;
          else           cnt     <= cnt - CW'(1);
        end
        RESPOND: last_grant <= req_q.is_data;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state so reset clears them at once.
  always_comb begin
    memEnable      = (state == ACCESS);
    memWrite       = memEnable && req_q.wr;
    memLaneMask    = memEnable ? req_q.mask : 4'b0;
    memAddr        = memEnable ? {req_q.addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    memWriteData   = memWrite ? req_q.wdata : 32'b0;
    fetchDone      = (state == RESPOND) && !req_q.is_data;
    dataDone       = (state == RESPOND) && req_q.is_data;
    fetchData      = fetchDone ? rdata_q : 32'b0;
    dataReadData   = dataDone ? rdata_q : 32'b0;
    dataMisaligned = dataDone && req_q.mis;
  end

endmodule

// File: tb/tb_mips_memory_arbiter.sv
// Self-checking bench for mips_memory_arbiter: directed vector table,
// arbitration and reset sequences, randomized transactions against a model.
module tb_mips_memory_arbiter;
  localparam int LAT = 2;

  logic        clock = 1'b0, reset;
  logic        fetchReq, dataReq, dataWriteEnable;
  logic [31:0] fetchAddr, dataAddr, dataWriteData, memReadData;
  logic [1:0]  dataByteEnable;
  logic        fetchDone, dataDone, dataMisaligned, memEnable, memWrite;
  logic [31:0] fetchData, dataReadData, memAddr, memWriteData;
  logic [3:0]  memLaneMask;

  mips_memory_arbiter #(.ADDR_WIDTH(32), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .fetchDone(fetchDone), .fetchData(fetchData),
    .dataReq(dataReq), .dataWriteEnable(dataWriteEnable),
    .dataByteEnable(dataByteEnable), .dataAddr(dataAddr),
    .dataWriteData(dataWriteData), .dataDone(dataDone),
    .dataReadData(dataReadData), .dataMisaligned(dataMisaligned),
    .memEnable(memEnable), .memWrite(memWrite), .memLaneMask(memLaneMask),
    .memAddr(memAddr), .memWriteData(memWriteData), .memReadData(memReadData)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clock)
    if (!reset && fetchDone && dataDone) chk("both_done", 32'(fetchDone & dataDone), 32'd0);

  typedef struct {
    logic        isd, we;
    logic [1:0]  be;
    logic [31:0] addr, wd, mw;
    int          lat, en;
    logic [3:0]  mask;
    logic [31:0] maddr, mwd;
    logic        wr;
    logic [31:0] rd;
    logic        mis;
  } vec_t;

  function automatic vec_t mk(logic isd, logic we, logic [1:0] be, logic [31:0] addr,
                              logic [31:0] wd, logic [31:0] mw, int lat, int en,
                              logic [3:0] mask, logic [31:0] maddr, logic [31:0] mwd,
                              logic wr, logic [31:0] rd, logic mis);
    vec_t v;
    v.isd = isd; v.we = we; v.be = be; v.addr = addr; v.wd = wd; v.mw = mw;
    v.lat = lat; v.en = en; v.mask = mask; v.maddr = maddr; v.mwd = mwd;
    v.wr = wr; v.rd = rd; v.mis = mis;
    return v;
  endfunction

  // Reference: access size in bytes, alignment by modulo, lanes and data by arithmetic.
  function automatic vec_t model(vec_t v);
    vec_t e = v;
    int n, off;
    longint unsigned piece, r;
    n   = !v.isd ? 4 : (v.be == 2'd1 ? 1 : v.be == 2'd2 ? 2 : v.be == 2'd3 ? 4 : 0);
    off = int'(v.addr % 4);
    e.lat = 1; e.en = 0; e.mask = 0; e.maddr = 0; e.mwd = 0; e.wr = 0; e.rd = 0; e.mis = 0;
    if (n != 0 && (off % n) != 0) e.mis = 1;
    else if (n != 0) begin
      e.lat   = LAT + 1;
      e.en    = LAT;
      e.mask  = 4'(((1 << n) - 1) << off);
      e.maddr = v.addr - 32'(off);
      e.wr    = v.isd && v.we;
      piece   = longint'(v.wd) % (64'd1 << (8 * n));
      r = 0;
      for (int k = 0; k < 4; k += n) r |= piece << (8 * k);
      e.mwd = e.wr ? 32'(r) : 32'd0;
      e.rd  = e.wr ? 32'd0 : 32'((longint'(v.mw) >> (8 * off)) % (64'd1 << (8 * n)));
    end
    return e;
  endfunction

  task automatic clear_inputs();
    fetchReq = 0; fetchAddr = 0; dataReq = 0; dataWriteEnable = 0;
    dataByteEnable = 0; dataAddr = 0; dataWriteData = 0; memReadData = 0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".memEnable"}, 32'(memEnable), 0);
    chk({tag, ".memWrite"}, 32'(memWrite), 0);
    chk({tag, ".mask"}, 32'(memLaneMask), 0);
    chk({tag, ".memAddr"}, memAddr, 0);
    chk({tag, ".memWData"}, memWriteData, 0);
    chk({tag, ".dones"}, 32'({fetchDone, dataDone, dataMisaligned}), 0);
    chk({tag, ".fetchData"}, fetchData, 0);
    chk({tag, ".dataRData"}, dataReadData, 0);
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
  endtask

  // Issue one request from IDLE and record what the DUT does until done.
  task automatic do_txn(input vec_t v, input bit perturb, output vec_t o);
    bit done = 0;
    o = v; o.lat = 0; o.en = 0; o.mask = 0; o.maddr = 0; o.mwd = 0; o.wr = 0; o.rd = 0; o.mis = 0;
    memReadData = v.mw;
    if (v.isd) begin
      dataReq = 1; dataWriteEnable = v.we; dataByteEnable = v.be;
      dataAddr = v.addr; dataWriteData = v.wd;
    end else begin
      fetchReq = 1; fetchAddr = v.addr;
    end
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clock);
      if (memEnable) begin
        o.en++; o.mask = memLaneMask; o.maddr = memAddr;
        o.mwd = memWriteData; o.wr = o.wr | memWrite;
      end
      if (fetchDone || dataDone) begin
        done  = 1;
        o.lat = cyc;
        o.rd  = v.isd ? dataReadData : fetchData;
        o.mis = dataMisaligned;
        chk("done_port", 32'(dataDone), 32'(v.isd));
      end else if (cyc == 1 && perturb) begin
        // Latched copy must be used; scramble live inputs and maybe drop the request.
        dataAddr = $urandom; dataWriteData = $urandom; fetchAddr = $urandom;
        dataByteEnable = 2'($urandom); dataWriteEnable = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin fetchReq = 0; dataReq = 0; end
      end
    end
    if (!done) chk("txn_timeout", 32'(done), 1);
    fetchReq = 0; dataReq = 0;
    @(negedge clock);
  endtask

  task automatic compare(input string tag, input vec_t o, input vec_t e);
    chk({tag, ".lat"}, 32'(o.lat), 32'(e.lat));
    chk({tag, ".en"}, 32'(o.en), 32'(e.en));
    chk({tag, ".mask"}, 32'(o.mask), 32'(e.mask));
    chk({tag, ".maddr"}, o.maddr, e.maddr);
    chk({tag, ".mwd"}, o.mwd, e.mwd);
    chk({tag, ".wr"}, 32'(o.wr), 32'(e.wr));
    chk({tag, ".rd"}, o.rd, e.rd);
    chk({tag, ".mis"}, 32'(o.mis), 32'(e.mis));
  endtask

  // which: 0 fetch, 1 data, -1 timeout; cyc: negedges waited
  task automatic wait_done(output int which, output int cyc);
    which = -1; cyc = 0;
    for (int i = 1; i <= 40 && which < 0; i++) begin
      @(negedge clock);
      if (dataDone) begin which = 1; cyc = i; end
      else if (fetchDone) begin which = 0; cyc = i; end
    end
  endtask

  vec_t tbl[10];
  vec_t o, e, v;
  int   w, c;

  initial begin
    tbl[0] = mk(0, 0, 2'd3, 32'h100, 0, 32'h8C220004, 3, 2, 4'hF, 32'h100, 0, 0, 32'h8C220004, 0);
    tbl[1] = mk(1, 1, 2'd1, 32'h203, 32'hAB, 0, 3, 2, 4'h8, 32'h200, 32'hABABABAB, 1, 0, 0);
    tbl[2] = mk(1, 0, 2'd2, 32'h402, 0, 32'hBEEF1234, 3, 2, 4'hC, 32'h400, 0, 0, 32'h0000BEEF, 0);
    tbl[3] = mk(1, 0, 2'd1, 32'h401, 0, 32'hBEEF1234, 3, 2, 4'h2, 32'h400, 0, 0, 32'h00000012, 0);
    tbl[4] = mk(1, 1, 2'd3, 32'h006, 32'h11223344, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[5] = mk(1, 1, 2'd0, 32'h010, 32'hFF, 32'h55, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[6] = mk(1, 0, 2'd2, 32'h003, 0, 32'hAAAA, 1, 0, 0, 0, 0, 0, 0, 1);
    tbl[7] = mk(1, 1, 2'd2, 32'h102, 32'h12345678, 0, 3, 2, 4'hC, 32'h100, 32'h56785678, 1, 0, 0);
    tbl[8] = mk(1, 0, 2'd3, 32'h800, 0, 32'hCAFEF00D, 3, 2, 4'hF, 32'h800, 0, 0, 32'hCAFEF00D, 0);
    tbl[9] = mk(1, 0, 2'd1, 32'h007, 0, 32'hBEEF1234, 3, 2, 4'h8, 32'h004, 0, 0, 32'h000000BE, 0);

    // Reset state
    reset = 1; clear_inputs();
    repeat (2) @(negedge clock);
    chk_quiet("reset");
    reset = 0;
    @(negedge clock);
    chk_quiet("post_reset");

    // Directed vectors
    foreach (tbl[i]) begin
      do_txn(tbl[i], 0, o);
      compare($sformatf("vec%0d", i), o, tbl[i]);
    end

    // Arbitration: data wins first tie, fetch next, then data again
    do_reset();
    fetchReq = 1; fetchAddr = 32'h40; dataReq = 1; dataWriteEnable = 0;
    dataByteEnable = 2'd3; dataAddr = 32'h80; memReadData = 32'h1234ABCD;
    wait_done(w, c);
    chk("arb1.who", 32'(w), 1);
    chk("arb1.lat", 32'(c), LAT + 1);
    dataReq = 0;
    wait_done(w, c);
    chk("arb2.who", 32'(w), 0);
    chk("arb2.gap", 32'(c), LAT + 2);
    chk("arb2.data", fetchData, 32'h1234ABCD);
    fetchReq = 0;
    @(negedge clock);
    fetchReq = 1; dataReq = 1;
    wait_done(w, c);
    chk("arb3.who", 32'(w), 1);
    dataReq = 0;
    wait_done(w, c);
    chk("arb4.who", 32'(w), 0);
    fetchReq = 0;
    @(negedge clock);

    // Reset during the first ACCESS cycle of a store
    dataReq = 1; dataWriteEnable = 1; dataByteEnable = 2'd1;
    dataAddr = 32'h203; dataWriteData = 32'hAB;
    @(negedge clock);
    chk("rstmid.write_before", 32'(memWrite), 1);
    #1 reset = 1;
    #1;
    chk("rstmid.write_after", 32'(memWrite), 0);
    chk("rstmid.enable_after", 32'(memEnable), 0);
    dataReq = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      c += int'(dataDone);
    end
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      c += int'(dataDone);
    end
    chk("rstmid.no_done", 32'(c), 0);
    chk_quiet("rstmid.idle");

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.isd  = ($urandom_range(0, 2) != 0);
      v.we   = 1'($urandom);
      v.be   = 2'($urandom);
      v.addr = $urandom & 32'h0000FFFF;
      if (!v.isd) v.addr[1:0] = 2'b00;
      v.wd   = $urandom;
      v.mw   = $urandom;
      e = model(v);
      do_txn(v, 1, o);
      compare($sformatf("rnd%0d", i), o, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
